rs_drive_ctrl: RTL and testbench
================================

RS_DRIVE_CTRL -- requirements
Module: rs_drive_ctrl

Interface
REQ-001 Parameter PULSE_W, default 4: active-low drive pulse width in clk cycles; legal range 1..255.
REQ-002 Parameter GAP_W, default 2: recovery cycles after each pulse, both drives high; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 set_req  input  1  single-cycle strobe requesting a set pulse.
REQ-006 rst_req  input  1  single-cycle strobe requesting a reset pulse.
REQ-007 clr_err  input  1  single-cycle strobe clearing err.
REQ-008 q  input  1  feedback from the downstream NAND RS latch q output.
REQ-009 s_n  output  1  active-low set drive to the latch s input.
REQ-010 r_n  output  1  active-low reset drive to the latch r input.
REQ-011 busy  output  1  high while a pulse or gap is in progress.
REQ-012 conflict  output  1  one-cycle pulse when set_req and rst_req are sampled in the same cycle.
REQ-013 err  output  1  sticky flag: latch feedback disagreed with the last commanded state.

Function
REQ-014 The FSM SHALL have the states IDLE, PULSE_S, PULSE_R and GAP.
REQ-015 s_n and r_n SHALL be registered outputs, and s_n=0 with r_n=0 SHALL never occur (forbidden NAND latch state).
REQ-016 IDLE transitions: pending or sampled reset goes to PULSE_R; otherwise pending or sampled set goes to PULSE_S; otherwise stay in IDLE.
REQ-017 A strobe sampled in IDLE at edge t SHALL drive its output low from edge t+1 for exactly PULSE_W cycles.
REQ-018 PULSE_S or PULSE_R SHALL transition to GAP after PULSE_W cycles, and GAP SHALL transition to IDLE after GAP_W cycles.
REQ-019 An 8-bit down-counter SHALL time both pulse and gap: it is loaded on state entry and the exit is taken at count 1.
REQ-020 A strobe arriving while busy=1 SHALL set a one-deep pending bit per request type; duplicate strobes SHALL merge.
REQ-021 Pending bits SHALL be served on the IDLE cycle after GAP, reset first, and the served bit SHALL be cleared on PULSE entry.
REQ-022 Simultaneous set_req and rst_req (either sampled or both pending) SHALL serve reset, drop set, and pulse conflict for one cycle.
REQ-023 A pending set and a pending reset from different cycles SHALL both be served, reset first.
REQ-024 q SHALL be sampled on the last GAP cycle; expected value is 1 after PULSE_S and 0 after PULSE_R; a mismatch SHALL set err.
REQ-025 err SHALL clear on clr_err unless a mismatch is detected in the same cycle, in which case set wins.
REQ-026 busy SHALL be 1 in PULSE_S, PULSE_R and GAP, and 0 in IDLE.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, s_n=1, r_n=1, busy=0, conflict=0, err=0, clear the pending bits and set the counter to 0.
REQ-028 Reset asserted during a pulse SHALL return the drive to 1 at the same edge; no partial pulse resumes after reset.
REQ-029 Strobes sampled while rst_n=0 SHALL be ignored.

Structure
REQ-030 The FSM state enum, the counter width constant and the pulse and gap parameter defaults SHALL live in a shared package rs_pkg.
REQ-031 A single sub-module rs_pulse_timer (load, value, done) SHALL implement the down-counter; everything else stays flat.
REQ-032 The bench SHALL instantiate rs_drive_ctrl driving the existing NAND rslatch gate model with a 1-unit gate delay, and feed latch q back to the q input.

Verification
REQ-033 Set, then reset: set_req at cycle 10 -> s_n low for cycles 11-14, busy for cycles 11-16, latch q=1, err=0; rst_req at cycle 20 -> r_n low for cycles 21-24, q=0.
REQ-034 Simultaneous strobes: set_req=rst_req=1 at cycle 5 -> conflict=1 at cycle 6, only r_n pulses, s_n stays 1 throughout.
REQ-035 Pending while busy: set_req at cycle 0, then rst_req and set_req at cycles 2 and 3 -> S pulse for cycles 1-4, gap, IDLE at cycle 7, R pulse for cycles 8-11, gap, IDLE at cycle 14, S pulse for cycles 15-18; the invariant s_n|r_n=1 is asserted every cycle.
REQ-036 Fault: tie q=0, issue set_req -> err=1 after the GAP check and stays 1; clr_err -> err=0; clr_err while a new mismatch is detected -> err stays 1.
REQ-037 Reset mid-pulse: rst_n=0 during the 2nd PULSE_S cycle -> s_n=1 and busy=0 next edge; pending bits are cleared and no pulse follows the release of rst_n.
REQ-038 Parameter corners: PULSE_W=1, GAP_W=1 and PULSE_W=255 -> low-pulse widths of exactly 1 and 255 cycles respectively; the counter does not wrap.

Source files
------------

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared types and constants for the RS latch drive controller
// Purpose: FSM state encoding, timer counter width and default pulse/gap timing
//          shared by rs_drive_ctrl and rs_pulse_timer.
// Ports:   none (package).
package rs_pkg;

  localparam int CNT_W       = 8;
  localparam int PULSE_W_DEF = 4;
  localparam int GAP_W_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE_S = 2'd1,
    ST_PULSE_R = 2'd2,
    ST_GAP     = 2'd3
  } rs_state_t;

endpackage

// File: rtl/rs_pulse_timer.sv
// rtl/rs_pulse_timer.sv - loadable down-counter timing drive pulses and gaps
// Purpose: counts a loaded value down to zero; done marks the last cycle of
//          the timed interval (count == 1), so a load of N spans N cycles.
// Ports:   clk   - clock
//          rst_n - synchronous active-low reset, clears the count
//          load  - load value on this edge (takes priority over counting)
//          value - interval length in cycles, 1..255
//          done  - high while the count is 1
module rs_pulse_timer
  import rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  // Counting stops at zero so an idle timer never wraps back to 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign done = (r_count == CNT_W'(1));

endmodule

// File: rtl/rs_drive_ctrl.sv
// rtl/rs_drive_ctrl.sv - pulse driver for a downstream NAND RS latch
// Purpose: converts set/reset strobes into timed active-low drive pulses
//          followed by a recovery gap, queues one request of each type while
//          busy, resolves set/reset collisions in favour of reset, and checks
//          the latch feedback at the end of every gap.
// Ports:   clk      - clock
//          rst_n    - synchronous active-low reset
//          set_req  - one-cycle set request strobe
//          rst_req  - one-cycle reset request strobe
//          clr_err  - one-cycle strobe clearing err
//          q        - latch q feedback
//          s_n      - registered active-low set drive
//          r_n      - registered active-low reset drive
//          busy     - pulse or gap in progress
//          conflict - one-cycle flag after simultaneous set/reset strobes
//          err      - sticky latch feedback mismatch
module rs_drive_ctrl
  import rs_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic rst_req,
  input  logic clr_err,
  input  logic q,
  output logic s_n,
  output logic r_n,
  output logic busy,
  output logic conflict,
  output logic err
);

  rs_state_t        r_state;
  rs_state_t        w_next;

  logic             r_pend_s;
  logic             r_pend_r;
  logic             r_exp_q;
  logic             r_s_n;
  logic             r_r_n;
  logic             r_conflict;
  logic             r_err;

  logic             w_set_in;
  logic             w_want_r;
  logic             w_want_s;
  logic             w_serve_r;
  logic             w_serve_s;
  logic             w_done;
  logic             w_load;
  logic [CNT_W-1:0] w_value;
  logic             w_s_n_d;
  logic             w_r_n_d;
  logic             w_busy;
  logic             w_gap_last;
  logic             w_mismatch;

  // A set strobe that coincides with a reset strobe is dropped outright.
  assign w_set_in = set_req & ~rst_req;
  assign w_want_r = r_pend_r | rst_req;
  assign w_want_s = r_pend_s | w_set_in;

  rs_pulse_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .value (w_value),
    .done  (w_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_want_r) begin
          w_next = ST_PULSE_R;
        end else if (w_want_s) begin
          w_next = ST_PULSE_S;
        end
      end
      ST_PULSE_S, ST_PULSE_R: begin
        if (w_done) begin
          w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_done) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic. Drives are decoded from the next state and registered, so a
  // strobe sampled at edge t pulls its drive low from edge t+1. Since w_next
  // holds exactly one state, both drives can never be low together.
  always_comb begin
    w_load     = 1'b0;
    w_value    = '0;
    w_s_n_d    = (w_next != ST_PULSE_S);
    w_r_n_d    = (w_next != ST_PULSE_R);
    w_busy     = (r_state != ST_IDLE);
    w_serve_r  = (r_state == ST_IDLE) && (w_next == ST_PULSE_R);
    w_serve_s  = (r_state == ST_IDLE) && (w_next == ST_PULSE_S);
    w_gap_last = (r_state == ST_GAP) && w_done;
    w_mismatch = w_gap_last && (q != r_exp_q);
    if (w_next != r_state) begin
      case (w_next)
        ST_PULSE_S, ST_PULSE_R: begin
          w_load  = 1'b1;
          w_value = CNT_W'(PULSE_W);
        end
        ST_GAP: begin
          w_load  = 1'b1;
          w_value = CNT_W'(GAP_W);
        end
        default: begin
          w_load  = 1'b0;
          w_value = '0;
        end
      endcase
    end
  end

  // Drive, pending, conflict and error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_n      <= 1'b1;
      r_r_n      <= 1'b1;
      r_conflict <= 1'b0;
      r_err      <= 1'b0;
      r_pend_s   <= 1'b0;
      r_pend_r   <= 1'b0;
      r_exp_q    <= 1'b0;
    end else begin
      r_s_n      <= w_s_n_d;
      r_r_n      <= w_r_n_d;
      r_conflict <= set_req & rst_req;
      // Any request not taken this cycle is held; the one taken is cleared.
      r_pend_r   <= w_want_r & ~w_serve_r;
      r_pend_s   <= w_want_s & ~w_serve_s;
      if (w_serve_s) begin
        r_exp_q <= 1'b1;
      end else if (w_serve_r) begin
        r_exp_q <= 1'b0;
      end
      // A mismatch found in the same cycle as clr_err keeps err set.
      r_err      <= w_mismatch | (r_err & ~clr_err);
    end
  end

  assign s_n      = r_s_n;
  assign r_n      = r_r_n;
  assign busy     = w_busy;
  assign conflict = r_conflict;
  assign err      = r_err;

endmodule

// File: tb/tb_rs_drive_ctrl.sv
// tb/tb_rs_drive_ctrl.sv - scoreboard bench for rs_drive_ctrl with NAND latch model
module tb_rs_drive_ctrl;

  typedef struct {
    int ch;
    int start;
    int width;
  } pulse_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic set_req = 1'b0;
  logic rst_req = 1'b0;
  logic clr_err = 1'b0;
  logic use_tie = 1'b0;
  logic lat_ok  = 1'b0;
  logic mon_en  = 1'b0;
  logic c1_set  = 1'b0;
  logic c2_set  = 1'b0;

  logic s_n, r_n, busy, conflict, err;
  logic c1_s_n, c1_r_n, c1_busy, c1_conf, c1_err;
  logic c2_s_n, c2_r_n, c2_busy, c2_conf, c2_err;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int c0;
  int c1;

  pulse_t pq[$];
  int     cq[$];

  // NAND RS latch gate model, 1-unit gate delay, held in q=0 until reset.
  logic lq  = 1'b0;
  logic lqb = 1'b1;
  wire  ls  = lat_ok ? s_n : 1'b1;
  wire  lr  = lat_ok ? r_n : 1'b1;
  always @(ls or lqb) lq  <= #1 ~(ls & lqb);
  always @(lr or lq)  lqb <= #1 ~(lr & lq);
  wire  dut_q = use_tie ? 1'b0 : lq;

  rs_drive_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req),
    .clr_err(clr_err), .q(dut_q), .s_n(s_n), .r_n(r_n), .busy(busy),
    .conflict(conflict), .err(err)
  );

  rs_drive_ctrl #(.PULSE_W(1), .GAP_W(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .set_req(c1_set), .rst_req(1'b0),
    .clr_err(1'b0), .q(1'b1), .s_n(c1_s_n), .r_n(c1_r_n), .busy(c1_busy),
    .conflict(c1_conf), .err(c1_err)
  );

  rs_drive_ctrl #(.PULSE_W(255), .GAP_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .set_req(c2_set), .rst_req(1'b0),
    .clr_err(1'b0), .q(1'b1), .s_n(c2_s_n), .r_n(c2_r_n), .busy(c2_busy),
    .conflict(c2_conf), .err(c2_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void got_pulse(input int ch, input int st, input int w);
    pulse_t e;
    if (pq.size() == 0) begin
      n_chk = n_chk + 1;
      $display("FAIL unexpected_pulse: got ch=%0d start=%0d width=%0d, expected none", ch, st, w);
    end else begin
      e = pq.pop_front();
      chk("pulse_channel", ch, e.ch);
      chk("pulse_start", st, e.start);
      chk("pulse_width", w, e.width);
    end
  endfunction

  // Monitor: channels 0=s_n, 1=r_n, 2=PULSE_W=1 s_n, 3=PULSE_W=255 s_n
  logic [3:0] mon_prev = 4'hF;
  logic [3:0] mon_cur;
  int         mon_st[4];
  always @(negedge clk) begin
    mon_cur = {c2_s_n, c1_s_n, r_n, s_n};
    if (mon_en) begin
      chk("drive_exclusive", int'(s_n | r_n), 1);
      for (int i = 0; i < 4; i++) begin
        if (mon_prev[i] && !mon_cur[i]) mon_st[i] = cyc;
        if (!mon_prev[i] && mon_cur[i]) got_pulse(i, mon_st[i], cyc - mon_st[i]);
      end
      if (conflict) begin
        if (cq.size() == 0) begin
          n_chk = n_chk + 1;
          $display("FAIL unexpected_conflict: got conflict at cycle %0d, expected none", cyc);
        end else begin
          chk("conflict_cycle", cyc, cq.pop_front());
        end
      end
    end
    mon_prev = mon_cur;
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic strobe(input logic s, input logic r);
    set_req = s;
    rst_req = r;
    @(negedge clk);
    set_req = 1'b0;
    rst_req = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic expect_pulse(input int ch, input int st, input int w);
    pulse_t e;
    e.ch = ch;
    e.start = st;
    e.width = w;
    pq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_s_n", s_n, 1);
    chk("reset_r_n", r_n, 1);
    chk("reset_busy", busy, 0);
    chk("reset_conflict", conflict, 0);
    chk("reset_err", err, 0);
    lat_ok = 1'b1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Set then reset
    c0 = cyc;
    expect_pulse(0, c0 + 1, 4);
    strobe(1'b1, 1'b0);
    chk("A_busy_pulse", busy, 1);
    wait_to(c0 + 6);  chk("A_busy_gap", busy, 1);
    wait_to(c0 + 7);  chk("A_idle", busy, 0);
    chk("A_q_after_set", lq, 1);
    chk("A_err", err, 0);
    wait_to(c0 + 10);
    expect_pulse(1, c0 + 11, 4);
    strobe(1'b0, 1'b1);
    wait_to(c0 + 17); chk("A_q_after_rst", lq, 0);
    chk("A_err2", err, 0);

    // Pending requests while busy
    c0 = cyc;
    expect_pulse(0, c0 + 1, 4);
    expect_pulse(1, c0 + 8, 4);
    expect_pulse(0, c0 + 15, 4);
    strobe(1'b1, 1'b0);
    wait_to(c0 + 2);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    wait_to(c0 + 7);  chk("C_idle1", busy, 0);
    wait_to(c0 + 8);  chk("C_busy_r", busy, 1);
    wait_to(c0 + 14); chk("C_idle2", busy, 0);
    wait_to(c0 + 22); chk("C_q_final", lq, 1);
    chk("C_err", err, 0);

    // Simultaneous strobes
    c0 = cyc;
    cq.push_back(c0 + 1);
    expect_pulse(1, c0 + 1, 4);
    strobe(1'b1, 1'b1);
    wait_to(c0 + 2);  chk("B_conflict_one_cycle", conflict, 0);
    wait_to(c0 + 8);  chk("B_q_after_rst", lq, 0);
    chk("B_err", err, 0);

    // Feedback fault
    use_tie = 1'b1;
    c0 = cyc;
    expect_pulse(0, c0 + 1, 4);
    strobe(1'b1, 1'b0);
    wait_to(c0 + 6);  chk("D_err_before_check", err, 0);
    wait_to(c0 + 7);  chk("D_err_set", err, 1);
    wait_to(c0 + 10); chk("D_err_sticky", err, 1);
    clr_pulse();
    chk("D_err_cleared", err, 0);
    c1 = cyc;
    expect_pulse(0, c1 + 1, 4);
    strobe(1'b1, 1'b0);
    wait_to(c1 + 6);
    clr_pulse();
    chk("D_set_beats_clear", err, 1);
    use_tie = 1'b0;
    wait_to(c1 + 10);

    // Reset during the second PULSE_S cycle
    c0 = cyc;
    expect_pulse(0, c0 + 1, 2);
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b1);
    rst_n   = 1'b0;
    set_req = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    set_req = 1'b0;
    chk("E_s_n_released", s_n, 1);
    chk("E_busy_cleared", busy, 0);
    chk("E_err_cleared", err, 0);
    wait_to(c0 + 20); chk("E_stays_idle", busy, 0);

    // Parameter corners
    c0 = cyc;
    expect_pulse(2, c0 + 1, 1);
    c1_set = 1'b1;
    @(negedge clk);
    c1_set = 1'b0;
    chk("F1_busy_pulse", c1_busy, 1);
    wait_to(c0 + 2);  chk("F1_busy_gap", c1_busy, 1);
    wait_to(c0 + 3);  chk("F1_idle", c1_busy, 0);
    c0 = cyc;
    expect_pulse(3, c0 + 1, 255);
    c2_set = 1'b1;
    @(negedge clk);
    c2_set = 1'b0;
    wait_to(c0 + 255); chk("F2_still_low", c2_s_n, 0);
    wait_to(c0 + 257); chk("F2_busy_gap", c2_busy, 1);
    wait_to(c0 + 258); chk("F2_idle", c2_busy, 0);
    chk("F_c1_err", c1_err, 0);
    chk("F_c2_err", c2_err, 0);
    chk("F_c1_r_n", c1_r_n, 1);
    chk("F_c2_r_n", c2_r_n, 1);
    chk("F_c1_conflict", c1_conf, 0);
    chk("F_c2_conflict", c2_conf, 0);

    repeat (4) @(negedge clk);
    chk("pulse_queue_drained", pq.size(), 0);
    chk("conflict_queue_drained", cq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
